fetch_unit: RTL and testbench
=============================

Name: fetch_unit

Overview:
Instruction-fetch stage that sits directly upstream of the combinational instruction ROM. It owns the program counter and drives the ROM byte address. It captures the returned word into an IF/ID output register and hands it to decode over a valid/ready handshake. It also accepts PC redirects from execute for branches and jumps.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset.
NOP_INST, 32'h0000_0013, instruction word driven on out_inst while out_valid=0 (addi x0,x0,0).

Ports:
clk  in  1  single clock; all state updates on rising edge.
rst  in  1  synchronous, active-high reset.
imem_addr  out  32  byte address to instruction ROM; equals pc register combinationally.
imem_data  in  32  instruction word from ROM; combinational response to imem_addr, same cycle.
redirect_valid  in  1  execute requests a PC change this cycle.
redirect_pc  in  32  target byte address for the redirect.
out_valid  out  1  out_pc/out_inst hold a valid instruction for decode.
out_ready  in  1  decode accepts the instruction this cycle.
out_pc  out  32  byte address of out_inst.
out_inst  out  32  fetched instruction.
out_fault  out  1  fetch fault flag accompanying out_valid; tied 0 unless the optional feature is enabled.

Behaviour:
- Reset (rst=1 at edge): pc=RESET_PC, out_valid=0, out_pc=0, out_inst=NOP_INST, out_fault=0, state=RUN. Reset overrides every other input, including mid-stall or mid-redirect.
- Clock/reset are the only timing inputs. imem_addr=pc at all times with no register in between.
- FSM states:
  - RUN: normal fetch.
  - FAULT: fetch halted (only reachable with the optional feature).
- Priority each cycle: rst > redirect_valid > load > hold.
- Redirect (redirect_valid=1): out_valid<=0, out_inst<=NOP_INST, out_fault<=0, pc<=redirect_pc with bits[1:0] forced to 0. A wrong-path instruction in the output register is discarded even if out_ready=1 that cycle. Decode treats that handshake as void. Next state is RUN.
- Load condition: state=RUN and no redirect and (out_valid=0 or out_ready=1). On load: out_pc<=pc, out_inst<=imem_data, out_valid<=1, pc<=pc+4.
- Hold: out_valid=1 and out_ready=0. The output register and pc are unchanged, and imem_addr stays stable.
- Latency: the instruction at address A appears on out_inst one cycle after pc=A. Throughput is 1 instruction/cycle with out_ready held high. The first out_valid is the cycle after the reset edge plus one.
- Handshake rules:
  - Transfer occurs when out_valid & out_ready.
  - Once out_valid is asserted, out_pc and out_inst stay stable until transfer or redirect.
  - out_valid drops only on transfer without refill, redirect, or reset.
- Arithmetic: pc+4 is modulo 2^32. 32'hFFFF_FFFC wraps to 0 with no flag.
- Address aliasing beyond ROM size is a ROM property. Fetch does not check range.

Optional Feature:
Macro: FETCH_MISALIGN_TRAP_EN
- With macro: a redirect whose redirect_pc[1:0]!=0 sets pc=redirect_pc (unmasked) and moves the FSM to FAULT. On the next cycle it emits one entry with out_valid=1, out_fault=1, out_pc=redirect_pc, out_inst=NOP_INST. In FAULT it performs no further loads. It stays in FAULT until redirect or reset, and an aligned redirect returns it to RUN.
- Without macro: low two bits are masked, out_fault is constant 0, and the FAULT state is unreachable.

Decomposition:
- Shared package fetch_pkg:
  - state typedef (RUN, FAULT)
  - NOP_INST constant
  - default RESET_PC
  - PC_STEP=4
- One natural sub-module: fetch_pc_next, a combinational next-PC select (redirect/increment/hold, alignment masking).
- Output register and FSM stay in fetch_unit.

Test Plan:
1. Reset, then out_ready=1, ROM words [0]=0x00100093, [1]=0x00200113 -> out_valid rises the second cycle after reset with out_pc=0, out_inst=0x00100093, then out_pc=4, out_inst=0x00200113 back-to-back.
2. Stall: out_ready=0 for 3 cycles while out_valid=1, out_pc=8 -> out_pc/out_inst/imem_addr are constant for those cycles; on release, out_pc=12 follows the next cycle.
3. Redirect to 0x40 coincident with out_ready=1 and out_valid=1 -> the output register is flushed (out_valid=0 next cycle), then out_pc=0x40 one cycle later.
4. Redirect to 0xFFFF_FFFC -> out_pc=0xFFFF_FFFC, then out_pc=0x0000_0000 (wrap).
5. Assert rst during a stall with out_valid=1 -> the next cycle has out_valid=0, out_inst=0x00000013, imem_addr=RESET_PC.
6. Redirect to 0x42 -> without macro, out_pc=0x40; with FETCH_MISALIGN_TRAP_EN, one entry out_fault=1, out_pc=0x42, then no valid until a redirect to 0x80 resumes at 0x80.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction-fetch stage.
// Optional build macro used by the fetch files: FETCH_MISALIGN_TRAP_EN.
package fetch_pkg;

   typedef enum logic {
      RUN   = 1'b0,
      FAULT = 1'b1
   } fetch_state_t;

   localparam logic [31:0] NOP_INST         = 32'h0000_0013;  // addi x0,x0,0
   localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;
   localparam logic [31:0] PC_STEP          = 32'd4;
   localparam logic [31:0] PC_ALIGN_MASK    = 32'h0000_0003;

endpackage

// File: rtl/fetch_pc_next.sv
// Combinational next-PC select: redirect, sequential increment or hold.
// With FETCH_MISALIGN_TRAP_EN a misaligned redirect target is kept unmasked
// and flagged so the fetch FSM can report it; otherwise the low bits are cleared.
module fetch_pc_next
   import fetch_pkg::*;
(
   input  logic [31:0] pc,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_pc,
   input  logic        advance,
   output logic [31:0] pc_next,
   output logic        misaligned
);

   // Select the program counter for the next cycle; wrap of pc+4 is intentional.
   always_comb begin
      pc_next    = pc;
      misaligned = 1'b0;
      if (redirect_valid) begin
`ifdef FETCH_MISALIGN_TRAP_EN
         misaligned = ((redirect_pc & PC_ALIGN_MASK) != 32'd0);
         pc_next    = redirect_pc;
`else
         pc_next    = redirect_pc & ~PC_ALIGN_MASK;
`endif
      end else if (advance) begin
         pc_next = pc + PC_STEP;
      end
   end

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, addresses the combinational ROM and
// holds the fetched word in an IF/ID register behind a valid/ready handshake.
// Build macro FETCH_MISALIGN_TRAP_EN enables the misaligned-redirect fault path;
// without it the FAULT state is never entered and out_fault stays 0.
module fetch_unit
   import fetch_pkg::*;
#(
   parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
   parameter logic [31:0] NOP_WORD = NOP_INST
) (
   input  logic        clk,
   input  logic        rst,
   output logic [31:0] imem_addr,
   input  logic [31:0] imem_data,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_pc,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] out_pc,
   output logic [31:0] out_inst,
   output logic        out_fault
);

   fetch_state_t state, state_next;
   logic [31:0]  pc, pc_next;
   logic         misaligned;
   logic         load;
   logic         fault_load;
   logic         drain;
   logic         fault_sent;

   // The ROM sees the PC register directly; no extra pipeline stage.
   assign imem_addr = pc;

   fetch_pc_next u_pc_next (
      .pc             (pc),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .advance        (load),
      .pc_next        (pc_next),
      .misaligned     (misaligned)
   );

   // Next-state and register-update decisions; redirect beats load beats hold.
   always_comb begin
      state_next = state;
      load       = 1'b0;
      fault_load = 1'b0;
      drain      = 1'b0;
      if (redirect_valid) begin
         state_next = misaligned ? FAULT : RUN;
      end else begin
         unique case (state)
            RUN: begin
               load = !out_valid || out_ready;
            end
            FAULT: begin
               // One fault entry is reported, then the stage idles until redirected.
               fault_load = !fault_sent && (!out_valid || out_ready);
               drain      = out_valid && out_ready && !fault_load;
            end
            default: begin
               state_next = RUN;
            end
         endcase
      end
   end

   // State, PC and IF/ID output register; a redirect flushes any wrong-path entry.
   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= RUN;
         pc         <= RESET_PC;
         out_valid  <= 1'b0;
         out_pc     <= 32'd0;
         out_inst   <= NOP_WORD;
         out_fault  <= 1'b0;
         fault_sent <= 1'b0;
      end else begin
         state <= state_next;
         pc    <= pc_next;
         if (redirect_valid) begin
            out_valid  <= 1'b0;
            out_inst   <= NOP_WORD;
            out_fault  <= 1'b0;
            fault_sent <= 1'b0;
         end else if (load) begin
            out_valid <= 1'b1;
            out_pc    <= pc;
            out_inst  <= imem_data;
            out_fault <= 1'b0;
         end else if (fault_load) begin
            out_valid  <= 1'b1;
            out_pc     <= pc;
            out_inst   <= NOP_WORD;
            out_fault  <= 1'b1;
            fault_sent <= 1'b1;
         end else if (drain) begin
            out_valid <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed vector table, misaligned-redirect
// sequence (FETCH_MISALIGN_TRAP_EN aware) and a randomized stream scoreboard.
module tb_fetch_unit;

   localparam logic [31:0] NOP = 32'h0000_0013;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] imem_addr;
   logic [31:0] imem_data;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_pc;
   logic [31:0] out_inst;
   logic        out_fault;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   function automatic logic [31:0] rom(input logic [31:0] a);
      if (a == 32'h0) return 32'h0010_0093;
      if (a == 32'h4) return 32'h0020_0113;
      return (a * 32'h0001_0001) ^ 32'h0000_0033;
   endfunction

   assign imem_data = rom(imem_addr);

   fetch_unit dut (
      .clk            (clk),
      .rst            (rst),
      .imem_addr      (imem_addr),
      .imem_data      (imem_data),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .out_valid      (out_valid),
      .out_ready      (out_ready),
      .out_pc         (out_pc),
      .out_inst       (out_inst),
      .out_fault      (out_fault)
   );

   task automatic chk(input string name, input int idx, input logic [31:0] got, input logic [31:0] want);
      checks++;
      if (got !== want) begin
         errors++;
         $display("FAIL %s step %0d: got %h expected %h", name, idx, got, want);
      end
   endtask

   typedef struct {
      logic        rst;
      logic        redir;
      logic [31:0] rpc;
      logic        ready;
      logic        e_valid;
      logic        chk_pc;
      logic [31:0] e_pc;
      logic [31:0] e_inst;
      logic [31:0] e_addr;
   } vec_t;

   localparam int NV = 18;
   vec_t tbl[NV];

   task automatic drive(input logic r, input logic rv, input logic [31:0] rp, input logic rd);
      rst            = r;
      redirect_valid = rv;
      redirect_pc    = rp;
      out_ready      = rd;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic expect_out(input int idx, input logic v, input logic f, input logic [31:0] p,
                             input logic [31:0] ins, input logic [31:0] a);
      chk("out_valid", idx, {31'd0, out_valid}, {31'd0, v});
      chk("out_fault", idx, {31'd0, out_fault}, {31'd0, f});
      chk("out_pc", idx, out_pc, p);
      chk("out_inst", idx, out_inst, ins);
      chk("imem_addr", idx, imem_addr, a);
   endtask

   initial begin
      logic [31:0] exp_next;
      logic [31:0] tgt;
      logic [31:0] rnd;
      logic        v0, rdy, rdir;
      logic [31:0] p0, i0, a0;
      int          xfers;

      drive(1'b1, 1'b0, 32'h0, 1'b1);

      //             rst   redir rpc            rdy   valid chkpc pc             inst                addr
      tbl[0]  = '{1'b1, 1'b0, 32'h0,         1'b1, 1'b0, 1'b1, 32'h0,         NOP,                32'h0};
      tbl[1]  = '{1'b0, 1'b0, 32'h0,         1'b1, 1'b1, 1'b1, 32'h0,         32'h0010_0093,      32'h4};
      tbl[2]  = '{1'b0, 1'b0, 32'h0,         1'b1, 1'b1, 1'b1, 32'h4,         32'h0020_0113,      32'h8};
      tbl[3]  = '{1'b0, 1'b0, 32'h0,         1'b1, 1'b1, 1'b1, 32'h8,         rom(32'h8),         32'hC};
      tbl[4]  = '{1'b0, 1'b0, 32'h0,         1'b0, 1'b1, 1'b1, 32'h8,         rom(32'h8),         32'hC};
      tbl[5]  = '{1'b0, 1'b0, 32'h0,         1'b0, 1'b1, 1'b1, 32'h8,         rom(32'h8),         32'hC};
      tbl[6]  = '{1'b0, 1'b0, 32'h0,         1'b0, 1'b1, 1'b1, 32'h8,         rom(32'h8),         32'hC};
      tbl[7]  = '{1'b0, 1'b0, 32'h0,         1'b1, 1'b1, 1'b1, 32'hC,         rom(32'hC),         32'h10};
      tbl[8]  = '{1'b0, 1'b1, 32'h40,        1'b1, 1'b0, 1'b1, 32'hC,         NOP,                32'h40};
      tbl[9]  = '{1'b0, 1'b0, 32'h0,         1'b1, 1'b1, 1'b1, 32'h40,        rom(32'h40),        32'h44};
      tbl[10] = '{1'b0, 1'b1, 32'hFFFF_FFFC, 1'b1, 1'b0, 1'b1, 32'h40,        NOP,                32'hFFFF_FFFC};
      tbl[11] = '{1'b0, 1'b0, 32'h0,         1'b1, 1'b1, 1'b1, 32'hFFFF_FFFC, rom(32'hFFFF_FFFC), 32'h0};
      tbl[12] = '{1'b0, 1'b0, 32'h0,         1'b1, 1'b1, 1'b1, 32'h0,         32'h0010_0093,      32'h4};
      tbl[13] = '{1'b0, 1'b0, 32'h0,         1'b0, 1'b1, 1'b1, 32'h0,         32'h0010_0093,      32'h4};
      tbl[14] = '{1'b1, 1'b0, 32'h0,         1'b0, 1'b0, 1'b1, 32'h0,         NOP,                32'h0};
      tbl[15] = '{1'b0, 1'b0, 32'h0,         1'b1, 1'b1, 1'b1, 32'h0,         32'h0010_0093,      32'h4};
      tbl[16] = '{1'b0, 1'b0, 32'h0,         1'b1, 1'b1, 1'b1, 32'h4,         32'h0020_0113,      32'h8};
      tbl[17] = '{1'b0, 1'b1, 32'h100,       1'b1, 1'b0, 1'b0, 32'h0,         NOP,                32'h100};

      for (int k = 0; k < NV; k++) begin
         drive(tbl[k].rst, tbl[k].redir, tbl[k].rpc, tbl[k].ready);
         tick();
         chk("out_valid", k, {31'd0, out_valid}, {31'd0, tbl[k].e_valid});
         chk("out_fault", k, {31'd0, out_fault}, 32'd0);
         chk("out_inst", k, out_inst, tbl[k].e_inst);
         chk("imem_addr", k, imem_addr, tbl[k].e_addr);
         if (tbl[k].chk_pc) chk("out_pc", k, out_pc, tbl[k].e_pc);
      end

      // Misaligned redirect to 0x42.
      drive(1'b0, 1'b1, 32'h42, 1'b1);
      tick();
`ifdef FETCH_MISALIGN_TRAP_EN
      chk("mis_addr", 100, imem_addr, 32'h42);
      chk("mis_valid", 100, {31'd0, out_valid}, 32'd0);
      drive(1'b0, 1'b0, 32'h0, 1'b0);
      tick();
      expect_out(101, 1'b1, 1'b1, 32'h42, NOP, 32'h42);
      tick();
      expect_out(102, 1'b1, 1'b1, 32'h42, NOP, 32'h42);
      drive(1'b0, 1'b0, 32'h0, 1'b1);
      for (int k = 0; k < 3; k++) begin
         tick();
         chk("halt_valid", 103 + k, {31'd0, out_valid}, 32'd0);
         chk("halt_addr", 103 + k, imem_addr, 32'h42);
      end
      drive(1'b0, 1'b1, 32'h80, 1'b1);
      tick();
      chk("resume_valid", 106, {31'd0, out_valid}, 32'd0);
      chk("resume_addr", 106, imem_addr, 32'h80);
      drive(1'b0, 1'b0, 32'h0, 1'b1);
      tick();
      expect_out(107, 1'b1, 1'b0, 32'h80, rom(32'h80), 32'h84);
`else
      chk("mis_addr", 100, imem_addr, 32'h40);
      chk("mis_valid", 100, {31'd0, out_valid}, 32'd0);
      drive(1'b0, 1'b0, 32'h0, 1'b1);
      tick();
      expect_out(101, 1'b1, 1'b0, 32'h40, rom(32'h40), 32'h44);
      tick();
      expect_out(102, 1'b1, 1'b0, 32'h44, rom(32'h44), 32'h48);
`endif

      // Randomized stream: every accepted entry must continue the address stream.
      drive(1'b1, 1'b0, 32'h0, 1'b1);
      tick();
      exp_next = 32'h0;
      xfers    = 0;
      for (int n = 0; n < 2000; n++) begin
         rdy  = ($urandom % 4) != 0;
         rdir = ($urandom % 16) == 0;
         rnd  = $urandom;
`ifdef FETCH_MISALIGN_TRAP_EN
         tgt  = rnd & 32'hFFFF_FFFC;
`else
         tgt  = rnd;
`endif
         drive(1'b0, rdir, tgt, rdy);
         #1;
         v0 = out_valid; p0 = out_pc; i0 = out_inst; a0 = imem_addr;
         if (v0 && rdy && !rdir) begin
            chk("rnd_pc", n, p0, exp_next);
            chk("rnd_inst", n, i0, rom(p0));
            exp_next = p0 + 32'd4;
            xfers++;
         end
         @(posedge clk);
         #1;
         if (rdir) begin
            exp_next = tgt & 32'hFFFF_FFFC;
            chk("rnd_flush", n, {31'd0, out_valid}, 32'd0);
            chk("rnd_raddr", n, imem_addr, exp_next);
         end else if (v0 && !rdy) begin
            chk("rnd_hold_pc", n, out_pc, p0);
            chk("rnd_hold_inst", n, out_inst, i0);
            chk("rnd_hold_addr", n, imem_addr, a0);
         end else begin
            chk("rnd_fill", n, {31'd0, out_valid}, 32'd1);
         end
      end
      chk("rnd_progress", 0, {31'd0, xfers > 800}, 32'd1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
